// File: rtl/telemetry_pkg.sv
// telemetry_pkg
// Shared definitions for the telemetry receive path: default header bytes,
// payload layout (byte index of each field half) and the state types used
// by the UART receiver and the frame parser.
package telemetry_pkg;

  // Default frame header bytes.
  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  // Payload follows the two header bytes; fields are big-endian 12-bit.
  localparam int         PAYLOAD_LEN   = 6;
  localparam logic [2:0] IDX_BATT_HI   = 3'd0;
  localparam logic [2:0] IDX_BATT_LO   = 3'd1;
  localparam logic [2:0] IDX_CURR_HI   = 3'd2;
  localparam logic [2:0] IDX_CURR_LO   = 3'd3;
  localparam logic [2:0] IDX_TORQUE_HI = 3'd4;
  localparam logic [2:0] IDX_TORQUE_LO = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [1:0] {
    HUNT0   = 2'd0,
    HUNT1   = 2'd1,
    PAYLOAD = 2'd2
  } parse_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver. RX is synchronised through two flops; a falling edge
// starts a half-bit wait to the start-bit centre, after which each bit is
// sampled one full bit time later, LSB first.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   RX       asynchronous serial input, idles high
//   rx_byte  last received byte (valid while byte_rdy is high)
//   byte_rdy one-cycle pulse: byte received with a good stop bit
//   frm_err  one-cycle pulse: stop bit sampled low, byte discarded
module uart_rx_core
  import telemetry_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frm_err
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

  logic        rx_meta_reg;
  logic        rx_s;

  uart_state_t state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        byte_rdy_reg, byte_rdy_next;
  logic        frm_err_reg, frm_err_next;
  logic        expire;

  // Both synchroniser flops reset to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_s        <= rx_meta_reg;
    end
  end

  // A load of N gives an expiry N cycles later (expiry is the cycle the
  // counter reads 1), so BAUD_DIV spaces samples exactly one bit apart.
  assign expire = (cnt_reg == 12'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      byte_rdy_reg <= 1'b0;
      frm_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      byte_rdy_reg <= byte_rdy_next;
      frm_err_reg  <= frm_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    byte_rdy_next = 1'b0;
    frm_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = BAUD_HALF;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s) begin
            // Low pulse shorter than half a bit: ignore it.
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_next   = BAUD_FULL;
            bit_next   = 3'd0;
          end
        end else begin
          cnt_next = cnt_reg - 12'd1;
        end
      end
      DATA: begin
        if (expire) begin
          shift_next = {rx_s, shift_reg[7:1]};
          cnt_next   = BAUD_FULL;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - 12'd1;
        end
      end
      STOP: begin
        if (expire) begin
          state_next = IDLE;
          if (rx_s) begin
            byte_rdy_next = 1'b1;
          end else begin
            frm_err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 12'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_byte  = shift_reg;
  assign byte_rdy = byte_rdy_reg;
  assign frm_err  = frm_err_reg;

endmodule

// File: rtl/telemetry_rx.sv
// telemetry_rx
// Receives the sensorCondition telemetry stream (HDR0 HDR1 then batt,
// avg_curr, avg_torque as big-endian 12-bit fields) and presents the
// decoded values with a one-cycle pkt_vld strobe.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   RX      asynchronous serial input, idles high
//   batt    last decoded battery value
//   curr    last decoded average current
//   torque  last decoded average torque
//   pkt_vld one-cycle pulse when a full frame has been decoded
//   frm_err one-cycle pulse on a stop-bit error
module telemetry_rx
  import telemetry_pkg::*;
#(
  parameter int         BAUD_DIV = 434,
  parameter logic [7:0] HDR0     = telemetry_pkg::HDR0_DEF,
  parameter logic [7:0] HDR1     = telemetry_pkg::HDR1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        pkt_vld,
  output logic        frm_err
);

  logic [7:0] rx_byte;
  logic       byte_rdy;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err)
  );

  parse_state_t state_reg, state_next;
  logic [2:0]   idx_reg, idx_next;
  logic         load;

  logic [11:0]  batt_reg, curr_reg, torque_reg;
  logic         pkt_vld_reg;

  // Shadow of the payload. Only the low nibble of each hi byte matters.
  // The final (torque_lo) byte is taken straight from rx_byte as the
  // outputs load, which is what keeps pkt_vld one cycle after byte_rdy.
  logic [3:0]   shadow_hi [3];
  logic [7:0]   shadow_lo [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HUNT0;
      idx_reg   <= IDX_BATT_HI;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load       = 1'b0;
    if (frm_err) begin
      state_next = HUNT0;
    end else if (byte_rdy) begin
      case (state_reg)
        HUNT0: begin
          if (rx_byte == HDR0) state_next = HUNT1;
        end
        HUNT1: begin
          if (rx_byte == HDR1) begin
            state_next = PAYLOAD;
            idx_next   = IDX_BATT_HI;
          end else if (rx_byte != HDR0) begin
            // A repeated HDR0 may be the real start: keep waiting for HDR1.
            state_next = HUNT0;
          end
        end
        PAYLOAD: begin
          if (idx_reg == IDX_TORQUE_LO) begin
            state_next = HUNT0;
            load       = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
        default: state_next = HUNT0;
      endcase
    end
  end

  // Field gi occupies payload bytes 2*gi (hi) and 2*gi+1 (lo).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hi
      localparam logic [2:0] HI_IDX = 3'(2 * gi);
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_hi[gi] <= '0;
        end else if (byte_rdy && state_reg == PAYLOAD && idx_reg == HI_IDX) begin
          shadow_hi[gi] <= rx_byte[3:0];
        end
      end
    end
    for (gi = 0; gi < 2; gi++) begin : g_lo
      localparam logic [2:0] LO_IDX = 3'(2 * gi + 1);
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_lo[gi] <= '0;
        end else if (byte_rdy && state_reg == PAYLOAD && idx_reg == LO_IDX) begin
          shadow_lo[gi] <= rx_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      batt_reg    <= '0;
      curr_reg    <= '0;
      torque_reg  <= '0;
      pkt_vld_reg <= 1'b0;
    end else begin
      pkt_vld_reg <= load;
      if (load) begin
        batt_reg   <= {shadow_hi[0], shadow_lo[0]};
        curr_reg   <= {shadow_hi[1], shadow_lo[1]};
        torque_reg <= {shadow_hi[2], rx_byte};
      end
    end
  end

  assign batt    = batt_reg;
  assign curr    = curr_reg;
  assign torque  = torque_reg;
  assign pkt_vld = pkt_vld_reg;

endmodule
